// File: rtl/game_pkg.sv
// Shared encodings for the board controller: winner codes, FSM states and
// the four line directions swept during the win check.
package game_pkg;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_X    = 2'b01,
    WIN_O    = 2'b10,
    WIN_DRAW = 2'b11
  } winner_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_CHECK = 2'b01,
    S_OVER  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    DIR_H = 2'd0,
    DIR_V = 2'd1,
    DIR_D = 2'd2,
    DIR_A = 2'd3
  } dir_t;

  function automatic winner_t mover_win(input logic turn);
    return turn ? WIN_O : WIN_X;
  endfunction

endpackage

// File: rtl/board_ctrl_line_run_check.sv
// Combinational run-length test through one cell along one direction;
// walks both ways up to WIN_LEN-1 steps and stops at the board edge.
module line_run_check
  import game_pkg::*;
#(
  parameter int N       = 3,
  parameter int WIN_LEN = 3,
  localparam int CELLS  = N * N,
  localparam int IDXW   = $clog2(CELLS)
) (
  input  logic [CELLS-1:0] i_colour,
  input  logic [IDXW-1:0]  i_last_idx,
  input  logic [1:0]       i_dir,
  output logic             o_win
);

  int              w_row, w_col, w_dr, w_dc, w_r, w_c, w_run;
  logic            w_alive;
  logic [IDXW-1:0] w_idx;

  always_comb begin
    w_row   = int'(i_last_idx) / N;
    w_col   = int'(i_last_idx) % N;
    w_dr    = 0;
    w_dc    = 1;
    w_r     = 0;
    w_c     = 0;
    w_run   = 1;
    w_alive = 1'b1;
    w_idx   = '0;
    unique case (i_dir)
      DIR_H:   begin w_dr = 0; w_dc = 1;  end
      DIR_V:   begin w_dr = 1; w_dc = 0;  end
      DIR_D:   begin w_dr = 1; w_dc = 1;  end
      default: begin w_dr = 1; w_dc = -1; end
    endcase
    // s=0 walks forward along (dr,dc), s=1 walks backward; a gap or edge ends the walk
    for (int unsigned s = 0; s < 2; s++) begin
      w_alive = 1'b1;
      for (int unsigned k = 1; k < WIN_LEN; k++) begin
        w_r = (s == 0) ? w_row + int'(k) * w_dr : w_row - int'(k) * w_dr;
        w_c = (s == 0) ? w_col + int'(k) * w_dc : w_col - int'(k) * w_dc;
        if (w_r < 0 || w_r >= N || w_c < 0 || w_c >= N) begin
          w_alive = 1'b0;
        end else begin
          w_idx = IDXW'(w_r * N + w_c);
          if (!i_colour[w_idx]) w_alive = 1'b0;
        end
        if (w_alive) w_run = w_run + 1;
      end
    end
    o_win = (w_run >= WIN_LEN);
  end

endmodule

// File: rtl/board_ctrl.sv
// N x N two-player board controller: move handshake and validation,
// occupancy storage, and a fixed four-cycle win/draw check per move.
module board_ctrl
  import game_pkg::*;
#(
  parameter int N       = 3,
  parameter int WIN_LEN = 3,
  localparam int CELLS  = N * N,
  localparam int IDXW   = $clog2(CELLS),
  localparam int CNTW   = $clog2(CELLS + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             new_game,
  input  logic             move_valid,
  input  logic [IDXW-1:0]  move_idx,
  output logic             move_ready,
  output logic             err,
  output logic [CELLS-1:0] x_state,
  output logic [CELLS-1:0] o_state,
  output logic             turn,
  output logic             game_over,
  output logic [1:0]       winner,
  output logic [CNTW-1:0]  move_count
);

  localparam logic [IDXW:0]   CELLS_IDX = (IDXW + 1)'(CELLS);
  localparam logic [CNTW-1:0] CELLS_CNT = CNTW'(CELLS);

  state_t           r_state, w_next;
  dir_t             r_dir;
  winner_t          r_winner;
  logic [CELLS-1:0] r_x_state, r_o_state;
  logic             r_turn, r_err, r_win_acc;
  logic [CNTW-1:0]  r_move_count;
  logic [IDXW-1:0]  r_last_idx;

  logic [CELLS-1:0] w_board, w_colour, w_onehot;
  logic             w_in_range, w_legal, w_accept, w_reject;
  logic             w_line_win, w_win_final, w_full, w_last_dir;

  assign w_board     = r_x_state | r_o_state;
  assign w_in_range  = {1'b0, move_idx} < CELLS_IDX;
  assign w_legal     = w_in_range && !w_board[move_idx];
  assign w_onehot    = CELLS'(1) << move_idx;
  assign w_colour    = r_turn ? r_o_state : r_x_state;
  assign w_full      = (r_move_count == CELLS_CNT);
  assign w_last_dir  = (r_dir == DIR_A);
  // Earlier-direction hits are accumulated so the outcome lands at a fixed cycle
  assign w_win_final = r_win_acc | w_line_win;

  line_run_check #(
    .N      (N),
    .WIN_LEN(WIN_LEN)
  ) u_line_run_check (
    .i_colour  (w_colour),
    .i_last_idx(r_last_idx),
    .i_dir     (r_dir),
    .o_win     (w_line_win)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_reject = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (move_valid) begin
          if (w_legal) begin
            w_accept = 1'b1;
            w_next   = S_CHECK;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      S_CHECK: begin
        if (w_last_dir) w_next = (w_win_final || w_full) ? S_OVER : S_IDLE;
      end
      S_OVER:  w_next = S_OVER;
      default: w_next = S_IDLE;
    endcase
    if (new_game) begin
      w_next   = S_IDLE;
      w_accept = 1'b0;
      w_reject = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_x_state    <= '0;
      r_o_state    <= '0;
      r_turn       <= 1'b0;
      r_move_count <= '0;
      r_winner     <= WIN_NONE;
      r_err        <= 1'b0;
      r_last_idx   <= '0;
      r_dir        <= DIR_H;
      r_win_acc    <= 1'b0;
    end else begin
      r_err <= w_reject;
      if (new_game) begin
        r_x_state    <= '0;
        r_o_state    <= '0;
        r_turn       <= 1'b0;
        r_move_count <= '0;
        r_winner     <= WIN_NONE;
        r_dir        <= DIR_H;
        r_win_acc    <= 1'b0;
      end else if (w_accept) begin
        if (r_turn) r_o_state <= r_o_state | w_onehot;
        else        r_x_state <= r_x_state | w_onehot;
        r_move_count <= r_move_count + CNTW'(1);
        r_last_idx   <= move_idx;
        r_dir        <= DIR_H;
        r_win_acc    <= 1'b0;
      end else if (r_state == S_CHECK) begin
        r_dir     <= dir_t'(r_dir + 2'd1);
        r_win_acc <= w_win_final;
        if (w_last_dir) begin
          if (w_win_final) r_winner <= mover_win(r_turn);
          else if (w_full) r_winner <= WIN_DRAW;
          else             r_turn   <= ~r_turn;
        end
      end
    end
  end

  assign move_ready = (r_state == S_IDLE);
  assign game_over  = (r_state == S_OVER);
  assign err        = r_err;
  assign x_state    = r_x_state;
  assign o_state    = r_o_state;
  assign turn       = r_turn;
  assign winner     = r_winner;
  assign move_count = r_move_count;

endmodule

// File: doc/board_ctrl.md
Name: board_ctrl

Overview:
Parametrised N x N board controller for the two-player game core; successor to the fixed 3x3 board and turn logic inside Game.
- Accepts one move per handshake and validates it.
- Stores X/O occupancy and alternates turns.
- Runs a fixed-latency, K-in-a-row win/draw check through the last placed cell.
- Feeds occupancy vectors to the VGA renderer and the AI move generator.

Parameters:
N, 3, board side length; legal range 3..8.
WIN_LEN, 3, run length that wins; legal range 2..N.
CELLS, N*N, derived; never overridden.
IDXW, clog2(CELLS), derived width of a cell index.

Ports:
clk  in  1  system clock (100 MHz)
clr  in  1  asynchronous active-high reset
new_game  in  1  synchronous restart pulse
move_valid  in  1  move request, held until accepted
move_idx  in  IDXW  cell index = row*N + col
move_ready  out  1  controller can accept a move
err  out  1  one-cycle pulse: illegal move rejected
x_state  out  CELLS  X occupancy; bit i = cell i
o_state  out  CELLS  O occupancy
turn  out  1  0 = X to move, 1 = O to move
game_over  out  1  level: game finished
winner  out  2  00 none, 01 X, 10 O, 11 draw
move_count  out  clog2(CELLS+1)  number of cells filled

Behaviour:
- Reset (clr high, asynchronous):
  - x_state=0, o_state=0, turn=0, move_count=0.
  - game_over=0, winner=00, err=0, move_ready=1.
  - FSM goes to IDLE.
- FSM states:
  - IDLE: move_ready=1.
  - CHECK: 4 cycles, one per direction. d0 = horizontal, d1 = vertical, d2 = main diagonal, d3 = anti-diagonal.
  - OVER: move_ready=0, game_over=1.
- Handshake: a move is accepted on a cycle where move_valid && move_ready.
- Legal move: move_idx < CELLS and the cell is empty in both vectors.
  - On the next edge, set the bit for the current turn in x_state/o_state and increment move_count.
  - Latch move_idx as last_idx and go to CHECK.
- Illegal move (idx out of range or occupied):
  - err=1 for exactly one cycle; board, turn and count unchanged.
  - Stay in IDLE with move_ready=1.
- CHECK detail:
  - Each cycle, combinationally test the current direction through last_idx.
  - Count contiguous cells of the mover's colour at offsets -(WIN_LEN-1)..+(WIN_LEN-1).
  - Walks stop at the board edge; no wrap across rows or columns.
  - Win when the run including last_idx is >= WIN_LEN.
  - Direction index advances 0..3; the mover's colour is held stable.
- Fixed latency:
  - Accept at cycle T; board updated at T+1; CHECK occupies T+1..T+4.
  - Outcome registered at the edge ending T+4, visible at T+5.
- Outcome priority:
  - Win found: winner = 01/10, go to OVER.
  - Else move_count==CELLS: winner=11, go to OVER.
  - Else toggle turn, return to IDLE (move_ready=1 at T+5).
- Early detection: a win found in an earlier direction is still reported only at T+5; latency is constant.
- During CHECK: move_ready=0 and move_valid is ignored. No err is raised for a move held across CHECK.
- OVER: moves are ignored and no err is raised; the FSM leaves OVER only on new_game or clr.
- new_game, in any state including mid-CHECK:
  - Next edge clears the board, turn, count, winner and game_over; go to IDLE.
  - It has priority over a simultaneous move, which is dropped with no err.
- clr mid-CHECK aborts immediately to reset values.

Decomposition:
- Package game_pkg holds:
  - winner encodings WIN_NONE/WIN_X/WIN_O/WIN_DRAW;
  - FSM state encodings S_IDLE/S_CHECK/S_OVER;
  - direction constants DIR_H/DIR_V/DIR_D/DIR_A.
- One sub-module, line_run_check: purely combinational. Inputs are the colour vector, last_idx and direction; output is a win flag. It is parametrised by N and WIN_LEN and instanced once.

Test Plan:
- N=3, WIN_LEN=3; moves 0,3,1,4,2 → after the 5th accept + 5 cycles: x_state=9'h007, o_state=9'h018, winner=01, game_over=1, move_ready=0.
- N=3; move 4, then move 4 again → err high exactly 1 cycle, o_state=0, turn=1, move_count=1.
- N=3; draw sequence 0,1,2,4,3,5,7,6,8 → winner=11, move_count=9, x_state=9'h18D, o_state=9'h072.
- N=5, WIN_LEN=4; X plays 0,6,12,18 and O plays 1,2,3 → winner=01 after the 7th move. Also N=5: X plays cells 3,4,5 (row wrap) → no win.
- Assert clr two cycles into CHECK → all outputs at reset values in the same cycle. Then new_game asserted together with move_valid → board stays empty and err=0.
- Hold move_valid with idx 7 during CHECK → move_ready=0 throughout and no err. The move is accepted on the first IDLE cycle at T+5.
